light_event_ctrl: RTL and testbench
===================================

// Module: light_event_ctrl
// PURPOSE
//  Avalon-MM slave that conditions NUM_CH light-sensor inputs and schedules their edge events to the Nios.
//  - Per channel: 2-FF synchroniser, then a debounce counter.
//  - Edge capture on the debounced level.
//  - Round-robin arbiter pushes pending edges into an event FIFO that software pops.
//  - Sits between the board sensor pins and the Nios IRQ line; replaces the single-bit edge PIO.
// PARAMETERS
//  NUM_CH      4   sensor channels, 1..8
//  DEBOUNCE_W  16  width of the debounce counter and its reload register
//  FIFO_DEPTH  8   event FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       synchronous, active-low reset
//  address    in   3       register word address
//  chipselect in   1       slave select
//  read_n     in   1       read strobe, active low
//  write_n    in   1       write strobe, active low
//  writedata  in   32      write data
//  in_port    in   NUM_CH  asynchronous sensor inputs
//  readdata   out  32      registered read data
//  irq        out  1       interrupt request, level
// BEHAVIOUR
//  Reset: sampled on clk; all state clears. readdata=0, irq=0, FIFO empty. CTRL=0. DEB_RELOAD=0 (no debounce).
//  Register map:
//   0 DATA  (RO)   debounced levels
//   1 DEB   (RW)   DEB_RELOAD
//   2 MASK  (RW)   irq_mask
//   3 EDGE  (RW1C) edge_capture
//   4 EVENT (RO, pop)
//   5 STATUS (RO; write clears OVF)
//   6 CTRL  (RW)   [0] en, [1] rise, [2] fall, [3] fifo_irq_en
//   7 reads 0
//  Read timing: readdata is updated every cycle from the addressed register (1-cycle latency).
//  Writes take effect the cycle after the strobe. Unused bits read 0.
//  Synchroniser: sync2 <= sync1 <= in_port.
//  Debounce:
//   - While sync2 == stable, counter = DEB_RELOAD.
//   - Otherwise counter decrements; when it is 0 and sync2 != stable, stable <= sync2.
//   - DEB_RELOAD=0 gives 3-cycle pin-to-stable latency.
//  Edge: stable 1->0 and CTRL.fall, or stable 0->1 and CTRL.rise, while CTRL.en -> edge[i]. Gated off when en=0.
//  EDGE register: edge[i] sets edge_capture[i]. A W1C write to the same bit in the same cycle loses to the set.
//  Pending: edge[i] sets pend[i]. If pend[i] is already 1, sticky OVF is set and the event is merged.
//  Arbiter:
//   - Each cycle, if pend!=0 and FIFO not full, grant the first pending channel after last_grant (round-robin).
//   - Push {ch} and clear pend[grant].
//   - FIFO full: nothing is pushed and pend holds; no event is lost beyond the merge rule.
//  EVENT read:
//   - readdata = {valid, 0.., ch[2:0]}, valid=[31]; head entry is presented.
//   - Pop happens on the cycle chipselect & ~read_n & address==4.
//   - Empty: reads 0 and no pop.
//   - Simultaneous push and pop while full is allowed (count unchanged).
//  STATUS: [3:0] count (a full FIFO of depth 8 reads 8, needs [3:0]), [8] empty, [9] full, [10] OVF. Any write clears OVF.
//  irq = |(edge_capture & irq_mask) | (CTRL.fifo_irq_en & ~empty). Driven from registers only; no comb path from the bus.
//  CTRL.en 1->0: pend and the FIFO are retained; only new edges are blocked.
// CONFIGURATION
//  LIGHT_EVT_TIMESTAMP_EN defined:
//   - 16-bit free-running cycle counter, wraps 0xFFFF->0, cleared on reset.
//   - Its value at push time is stored with each entry; EVENT[30:15] = timestamp.
//  Not defined: no counter; EVENT[30:3] read 0; FIFO entry is ch only.
// STRUCTURE
//  Package light_evt_pkg holds:
//   - register address localparams (ADDR_DATA..ADDR_CTRL)
//   - CTRL bit indices
//   - EVENT/STATUS field positions
//   - TS_W=16
//  Sub-module light_evt_debounce: synchroniser + debounce counter + edge detect, instantiated NUM_CH times.
//  Arbiter, FIFO and register file stay in the top level.
// TESTING
//  1 Reset, then read every address -> all 0, irq=0, STATUS.empty=1.
//  2 DEB=4, CTRL=0x5; ch0 high for 10 cycles then a 3-cycle low glitch
//    -> no edge; a 10-cycle low -> EDGE=0x1, FIFO count=1.
//  3 ch0..ch3 fall in the same cycle, last_grant=1 -> pushes in order 2,3,0,1 on consecutive cycles;
//    EVENT reads return ch 2,3,0,1, then valid=0.
//  4 Fill FIFO (8 events) while ch1 edge is pending -> pend holds and full=1; one pop -> ch1 pushed next cycle.
//    A second ch1 edge while pending -> STATUS.OVF=1.
//  5 MASK=0x2, edge on ch1 -> irq=1; write EDGE=0x2 -> irq=0 next cycle.
//    Write concurrent with a new edge -> bit stays 1.
//  6 With LIGHT_EVT_TIMESTAMP_EN: two edges 100 cycles apart
//    -> EVENT timestamps differ by 100 (mod 65536).

Source files
------------

// File: rtl/light_evt_pkg.sv
// Shared constants for the light-sensor event controller: register map, CTRL bits,
// EVENT/STATUS field positions and timestamp width.
package light_evt_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DEB    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_EVENT  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_RISE     = 1;
  localparam int unsigned CTRL_FALL     = 2;
  localparam int unsigned CTRL_FIFO_IRQ = 3;

  localparam int unsigned EVT_VALID   = 31;
  localparam int unsigned EVT_TS_LSB  = 15;
  localparam int unsigned STAT_EMPTY  = 8;
  localparam int unsigned STAT_FULL   = 9;
  localparam int unsigned STAT_OVF    = 10;

  localparam int unsigned TS_W = 16;
  localparam int unsigned CH_W = 3;

endpackage

// File: rtl/light_event_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line between the Nios and light_event_ctrl.
interface light_event_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/light_evt_debounce.sv
// One sensor channel: 2-FF synchroniser, reloadable debounce counter and edge pulse on the
// debounced level.
module light_evt_debounce #(
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pin,
  input  logic [DEBOUNCE_W-1:0] deb_reload,
  input  logic                  en,
  input  logic                  rise,
  input  logic                  fall,
  output logic                  level,
  output logic                  edge_evt
);

  logic                  sync1_q, sync2_q, stable_q, edge_q;
  logic [DEBOUNCE_W-1:0] cnt_q;
  logic                  flip;

  // The synchronised input has disagreed long enough for the counter to run out.
  assign flip = (sync2_q != stable_q) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= deb_reload;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (flip) begin
        stable_q <= sync2_q;
      end
      edge_q <= flip && en && (sync2_q ? rise : fall);
    end
  end

  assign level    = stable_q;
  assign edge_evt = edge_q;

endmodule

// File: rtl/light_event_ctrl.sv
// Light-sensor event controller: debounced channels, round-robin edge arbiter and event FIFO.
// Optional LIGHT_EVT_TIMESTAMP_EN stores a 16-bit cycle timestamp with each FIFO entry.
module light_event_ctrl
  import light_evt_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEBOUNCE_W = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  light_event_ctrl_if.slave    bus,
  input  logic [NUM_CH-1:0]    in_port
);

`ifdef LIGHT_EVT_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = CH_W + TS_W;
`else
  localparam int unsigned ENTRY_W = CH_W;
`endif
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_CH-1:0]     level, edge_vec;
  logic [DEBOUNCE_W-1:0] deb_reload_q;
  logic [NUM_CH-1:0]     mask_q, edge_cap_q, edge_cap_d, pend_q, pend_d, grant_oh, w1c;
  logic [3:0]            ctrl_q;
  logic                  ovf_q, ovf_set;
  logic [2:0]            last_grant_q, grant_idx;
  logic                  grant_valid, push, pop, empty, full, wr_en, rd_en;
  logic [ENTRY_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    head, push_entry;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [31:0]           rdata, readdata_q;
  logic [7:0]            pend8;
  logic [3:0]            cand;
  logic                  unused_wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    light_evt_debounce #(
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (in_port[g]),
      .deb_reload (deb_reload_q),
      .en         (ctrl_q[CTRL_EN]),
      .rise       (ctrl_q[CTRL_RISE]),
      .fall       (ctrl_q[CTRL_FALL]),
      .level      (level[g]),
      .edge_evt   (edge_vec[g])
    );
  end

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign rd_en        = bus.chipselect && !bus.read_n;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop          = rd_en && (bus.address == ADDR_EVENT) && !empty;
  assign head         = fifo_q[rd_ptr_q];
  assign pend8        = 8'(pend_q);
  assign unused_wdata = ^bus.writedata;

`ifdef LIGHT_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end
  assign push_entry = {ts_q, grant_idx};
`else
  assign push_entry = grant_idx;
`endif

  // Round-robin: first pending channel strictly after the last one granted.
  always_comb begin
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      cand = 4'(last_grant_q) + 4'(i);
      if (cand >= 4'(NUM_CH)) cand = cand - 4'(NUM_CH);
      if (!grant_valid && pend8[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
  assign push = grant_valid && (!full || pop);

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      grant_oh[i] = push && (grant_idx == 3'(i));
    end
    w1c        = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[NUM_CH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~w1c) | edge_vec;
    pend_d     = (pend_q & ~grant_oh) | edge_vec;
    ovf_set    = |(edge_vec & pend_q & ~grant_oh);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA: rdata[NUM_CH-1:0]     = level;
      ADDR_DEB:  rdata[DEBOUNCE_W-1:0] = deb_reload_q;
      ADDR_MASK: rdata[NUM_CH-1:0]     = mask_q;
      ADDR_EDGE: rdata[NUM_CH-1:0]     = edge_cap_q;
      ADDR_EVENT: begin
        if (!empty) begin
          rdata[EVT_VALID]  = 1'b1;
          rdata[CH_W-1:0]   = head[CH_W-1:0];
`ifdef LIGHT_EVT_TIMESTAMP_EN
          rdata[EVT_TS_LSB +: TS_W] = head[CH_W +: TS_W];
`endif
        end
      end
      ADDR_STATUS: begin
        rdata[CNT_W-1:0]  = count_q;
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_OVF]   = ovf_q;
      end
      ADDR_CTRL: rdata[3:0] = ctrl_q;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q   <= '0;
      deb_reload_q <= '0;
      mask_q       <= '0;
      ctrl_q       <= '0;
      edge_cap_q   <= '0;
      pend_q       <= '0;
      ovf_q        <= 1'b0;
      last_grant_q <= 3'(NUM_CH - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      readdata_q <= rdata;
      edge_cap_q <= edge_cap_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      if (wr_en) begin
        case (bus.address)
          ADDR_DEB:  deb_reload_q <= bus.writedata[DEBOUNCE_W-1:0];
          ADDR_MASK: mask_q       <= bus.writedata[NUM_CH-1:0];
          ADDR_CTRL: ctrl_q       <= bus.writedata[3:0];
          default:   ;
        endcase
      end
      // A new overflow in the clearing cycle must not be lost.
      if (ovf_set) ovf_q <= 1'b1;
      else if (wr_en && bus.address == ADDR_STATUS) ovf_q <= 1'b0;
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        last_grant_q <= grant_idx;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = (|(edge_cap_q & mask_q)) || (ctrl_q[CTRL_FIFO_IRQ] && !empty);

endmodule

// File: tb/tb_light_event_ctrl.sv
// Self-checking bench for light_event_ctrl: queue-based behavioural model compared every cycle,
// plus directed reads with hand-computed values.
module tb_light_event_ctrl;
  import light_evt_pkg::*;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned DEBOUNCE_W = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] in_port = '0;
  light_event_ctrl_if bus();

  light_event_ctrl #(
    .NUM_CH     (NUM_CH),
    .DEBOUNCE_W (DEBOUNCE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: state advanced once per rising edge from the bench's own inputs.
  typedef struct {int ch; int ts;} ev_t;
  ev_t         m_fifo[$];
  bit [NUM_CH-1:0] m_s1, m_s2, m_stable, m_edge_nxt, m_mask, m_ecap, m_pend;
  int          m_run[NUM_CH];
  int          m_deb, m_last, m_ts;
  bit [3:0]    m_ctrl;
  bit          m_ovf;
  logic [31:0] exp_rd = '0;
  logic        exp_irq = 1'b0;

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r = '0;
    case (a)
      0: r = 32'(m_stable);
      1: r = 32'(m_deb);
      2: r = 32'(m_mask);
      3: r = 32'(m_ecap);
      4: if (m_fifo.size() > 0) begin
           r = 32'h8000_0000 | 32'(m_fifo[0].ch);
`ifdef LIGHT_EVT_TIMESTAMP_EN
           r = r | (32'(m_fifo[0].ts & 16'hFFFF) << 15);
`endif
         end
      5: r = 32'(m_fifo.size()) | (32'(m_fifo.size() == 0) << 8)
           | (32'(m_fifo.size() == FIFO_DEPTH) << 9) | (32'(m_ovf) << 10);
      6: r = 32'(m_ctrl);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic m_step();
    bit [NUM_CH-1:0] edges;
    bit [3:0] old_ctrl;
    int old_deb, a, gr;
    bit cs_rd, cs_wr, pop, push;
    logic [31:0] wd;
    if (!reset_n) begin
      m_fifo.delete();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_edge_nxt = '0; m_mask = '0; m_ecap = '0;
      m_pend = '0; m_deb = 0; m_ctrl = '0; m_ovf = 0; m_ts = 0; m_last = NUM_CH - 1;
      for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
      exp_rd = '0;
      exp_irq = 1'b0;
      return;
    end
    a        = int'(bus.address);
    wd       = bus.writedata;
    cs_rd    = bus.chipselect && !bus.read_n;
    cs_wr    = bus.chipselect && !bus.write_n;
    exp_rd   = m_read(a);
    edges    = m_edge_nxt;
    old_ctrl = m_ctrl;
    old_deb  = m_deb;
    pop      = cs_rd && a == 4 && m_fifo.size() > 0;
    gr = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (gr < 0 && m_pend[(m_last + k) % NUM_CH]) gr = (m_last + k) % NUM_CH;
    end
    push = gr >= 0 && (m_fifo.size() < FIFO_DEPTH || pop);
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      m_fifo.push_back('{gr, m_ts});
      m_pend[gr] = 0;
      m_last = gr;
    end
    if (cs_wr && a == 5) m_ovf = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (edges[c]) begin
        if (m_pend[c]) m_ovf = 1;
        m_pend[c] = 1;
      end
    end
    if (cs_wr && a == 3) m_ecap = m_ecap & ~wd[NUM_CH-1:0];
    m_ecap = m_ecap | edges;
    if (cs_wr && a == 1) m_deb = int'(wd[DEBOUNCE_W-1:0]);
    if (cs_wr && a == 2) m_mask = wd[NUM_CH-1:0];
    if (cs_wr && a == 6) m_ctrl = wd[3:0];
    // Level follows the synchronised pin after it disagrees for reload+1 cycles.
    m_edge_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_s2[c] != m_stable[c]) begin
        m_run[c]++;
        if (m_run[c] > old_deb) begin
          m_stable[c]   = m_s2[c];
          m_edge_nxt[c] = old_ctrl[0] && (m_s2[c] ? old_ctrl[1] : old_ctrl[2]);
          m_run[c]      = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = in_port;
    m_ts = (m_ts + 1) & 16'hFFFF;
    exp_irq = (|(m_ecap & m_mask)) || (m_ctrl[3] && m_fifo.size() > 0);
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("readdata", bus.readdata, exp_rd);
      check("irq", {31'b0, bus.irq}, {31'b0, exp_irq});
    end
  end

  task automatic idle();
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = 3'd0; bus.writedata = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  // Event reads with the timestamp field masked so both builds share expectations.
  task automatic ev_chk(input string name, input logic [31:0] exp);
    logic [31:0] d;
    rd(ADDR_EVENT, d);
    check(name, d & 32'h8000_7FFF, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e1, e2;
    idle();
    wait_n(4);
    cmp_en = 1;
    reset_n = 1'b1;
    wait_n(2);

    // 1: reset values
    for (int a = 0; a < 8; a++) begin
      rd_chk("reset_read", 3'(a), (a == 5) ? 32'h0000_0100 : 32'h0);
    end
    check("reset_irq", {31'b0, bus.irq}, 32'h0);

    // 2: debounce rejects a short glitch, accepts a long fall
    wr(ADDR_DEB, 32'd4);
    wr(ADDR_CTRL, 32'h5);
    in_port[0] = 1'b1; wait_n(10);
    in_port[0] = 1'b0; wait_n(3);
    in_port[0] = 1'b1; wait_n(10);
    rd_chk("glitch_no_edge", ADDR_EDGE, 32'h0);
    rd_chk("data_high", ADDR_DATA, 32'h1);
    in_port[0] = 1'b0; wait_n(15);
    rd_chk("fall_edge", ADDR_EDGE, 32'h1);
    rd_chk("fall_count", ADDR_STATUS, 32'h1);
    ev_chk("fall_event", 32'h8000_0000);
    wr(ADDR_EDGE, 32'hF);

    // 3: round-robin after last_grant=1
    wr(ADDR_DEB, 32'd0);
    in_port = 4'b1110; wait_n(8);
    in_port = 4'b1100; wait_n(8);
    ev_chk("rr_prime", 32'h8000_0001);
    in_port = 4'b1111; wait_n(8);
    in_port = 4'b0000; wait_n(10);
    rd_chk("rr_count", ADDR_STATUS, 32'h4);
    ev_chk("rr_ev0", 32'h8000_0002);
    ev_chk("rr_ev1", 32'h8000_0003);
    ev_chk("rr_ev2", 32'h8000_0000);
    ev_chk("rr_ev3", 32'h8000_0001);
    ev_chk("rr_empty", 32'h0);
    rd_chk("rr_edge", ADDR_EDGE, 32'hF);
    wr(ADDR_EDGE, 32'hF);

    // 4: full FIFO holds pending ch1, overflow on merge
    wr(ADDR_CTRL, 32'h7);
    for (int i = 0; i < 8; i++) begin
      in_port[0] = ~in_port[0]; wait_n(6);
    end
    in_port[1] = 1'b1; wait_n(6);
    rd_chk("full_status", ADDR_STATUS, 32'h0000_0208);
    in_port[1] = 1'b0; wait_n(6);
    rd_chk("ovf_status", ADDR_STATUS, 32'h0000_0608);
    ev_chk("full_pop", 32'h8000_0000);
    wait_n(2);
    rd_chk("refill_status", ADDR_STATUS, 32'h0000_0608);
    wr(ADDR_STATUS, 32'h0);
    rd_chk("ovf_clear", ADDR_STATUS, 32'h0000_0208);
    for (int i = 0; i < 7; i++) ev_chk("drain_ch0", 32'h8000_0000);
    ev_chk("drain_ch1", 32'h8000_0001);
    rd_chk("drained", ADDR_STATUS, 32'h0000_0100);
    wr(ADDR_EDGE, 32'hF);

    // 5: irq from masked edge capture, W1C against a simultaneous set
    wr(ADDR_MASK, 32'h2);
    in_port[1] = 1'b1; wait_n(6);
    check("irq_set", {31'b0, bus.irq}, 32'h1);
    wr(ADDR_EDGE, 32'h2);
    check("irq_clear", {31'b0, bus.irq}, 32'h0);
    in_port[1] = 1'b0;
    wait_n(2);
    wr(ADDR_EDGE, 32'h2);
    rd_chk("w1c_loses", ADDR_EDGE, 32'h2);
    check("irq_kept", {31'b0, bus.irq}, 32'h1);
    wr(ADDR_EDGE, 32'h2);
    wr(ADDR_MASK, 32'h0);

    // FIFO-not-empty interrupt
    wr(ADDR_CTRL, 32'hF);
    check("fifo_irq", {31'b0, bus.irq}, 32'h1);
    ev_chk("fifo_ev0", 32'h8000_0001);
    ev_chk("fifo_ev1", 32'h8000_0001);
    check("fifo_irq_off", {31'b0, bus.irq}, 32'h0);
    wr(ADDR_CTRL, 32'h7);

`ifdef LIGHT_EVT_TIMESTAMP_EN
    // 6: timestamps of two edges 100 cycles apart
    in_port[2] = 1'b1;
    wait_n(100);
    in_port[2] = 1'b0;
    wait_n(10);
    rd(ADDR_EVENT, e1);
    rd(ADDR_EVENT, e2);
    check("ts_delta", 32'((e2[30:15] - e1[30:15]) & 16'hFFFF), 32'd100);
`else
    e1 = '0;
    e2 = '0;
`endif
    wait_n(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
